// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz sequence controller: FSM state
// encoding, result codes and the 3k+1 overflow threshold for a 20-bit k.
package collatz_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ZERO    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_OVF     = 2'd3;

   // Smallest odd k for which 3k+1 no longer fits in 20 bits.
   localparam logic [19:0] OVF_LIMIT = 20'd349525;

endpackage

// File: rtl/collatz_ctrl_if.sv
// Bus between the Collatz controller and its requester/datapath: start
// request, datapath status (k, step counter x), control strobes and the
// busy/done/err result signals.
interface collatz_ctrl_if;

   logic        st;
   logic [19:0] k;
   logic [15:0] x;
   logic        Rx, Mx, Sk, Pk, Ik, Ir, Pr, Mr;
   logic        busy;
   logic        done;
   logic [1:0]  err;

   // Requester plus datapath side.
   modport master (
      output st, k, x,
      input  Rx, Mx, Sk, Pk, Ik, Ir, Pr, Mr, busy, done, err
   );

   // Controller side.
   modport slave (
      input  st, k, x,
      output Rx, Mx, Sk, Pk, Ik, Ir, Pr, Mr, busy, done, err
   );

endinterface

// File: rtl/collatz_ctrl.sv
// Moore FSM sequencing an external Collatz datapath. LOAD copies the
// operand into k and clears x; each RUN cycle either halves k (even) or
// applies 3k+1 (odd) and bumps x, until k reaches 1 or an abort fires.
// Optional feature macro: COLLATZ_OVF_DET_EN enables the 3k+1 overflow
// abort (err=OVF); without it 3k+1 simply wraps modulo 2^20.
module collatz_ctrl
   import collatz_pkg::*;
#(
   parameter logic [15:0] MAX_STEPS = 16'hFFFF
)(
   input logic           clk,
   input logic           rst_n,
   collatz_ctrl_if.slave bus
);

   state_t     state, state_nxt;
   logic [1:0] err_q, err_nxt;

   logic k_one, k_zero, k_odd, timeout, ovf;
   logic rx, mx, sk, pk, ik, ir, pr, mr;
   logic busy, done;

   assign k_one   = (bus.k == 20'd1);
   assign k_zero  = (bus.k == 20'd0);
   assign k_odd   = bus.k[0];
   assign timeout = (bus.x == MAX_STEPS);

`ifdef COLLATZ_OVF_DET_EN
   assign ovf = k_odd && (bus.k >= OVF_LIMIT);
`else
   assign ovf = 1'b0;
`endif

   // State and result-code registers; reset forces IDLE with a clean result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         err_q <= ERR_OK;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
      end
   end

   // Next-state, result code and strobe decode from state, k and x.
   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      rx   = 1'b0;
      mx   = 1'b0;
      sk   = 1'b0;
      pk   = 1'b0;
      ik   = 1'b0;
      ir   = 1'b0;
      pr   = 1'b0;
      mr   = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: begin
            if (bus.st) state_nxt = LOAD;
         end
         LOAD: begin
            busy      = 1'b1;
            sk        = 1'b1;
            rx        = 1'b1;
            ir        = 1'b1;
            err_nxt   = ERR_OK;
            state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            // Abort checks ordered so that reaching k==1 always wins.
            if (k_one) begin
               err_nxt   = ERR_OK;
               state_nxt = DONE;
            end else if (k_zero) begin
               err_nxt   = ERR_ZERO;
               state_nxt = DONE;
            end else if (timeout) begin
               err_nxt   = ERR_TIMEOUT;
               state_nxt = DONE;
            end else if (ovf) begin
               err_nxt   = ERR_OVF;
               state_nxt = DONE;
            end else if (!k_odd) begin
               pk = 1'b1;
               pr = 1'b1;
               mx = 1'b1;
            end else begin
               ik = 1'b1;
               mr = 1'b1;
               mx = 1'b1;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.Rx   = rx;
   assign bus.Mx   = mx;
   assign bus.Sk   = sk;
   assign bus.Pk   = pk;
   assign bus.Ik   = ik;
   assign bus.Ir   = ir;
   assign bus.Pr   = pr;
   assign bus.Mr   = mr;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.err  = err_q;

endmodule
